// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp encodings,
// default busy-window lengths and the controller state encoding.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mdu_if.sv
// E-stage request / result bundle of the multiply/divide unit.
// master drives the request side, slave is the unit itself.
interface mdu_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output Start, MDOp, A, B, input Busy, HI, LO);
    modport slave  (input Start, MDOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Operands are latched on acceptance; the result is computed from the
// latched copies and committed when the busy window expires.
// Optional feature: define MDU_MADD_EN to enable the signed multiply-
// accumulate op (MDOp=6); otherwise MDOp=6 is a no-op like MDOp=7.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic   clk,
    input logic   reset,
    mdu_if.slave  md
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_e            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    md_op_e            op_p0, op_nxt;
    logic [31:0]       a_p0, a_nxt;
    logic [31:0]       b_p0, b_nxt;
    logic [31:0]       hi, hi_nxt;
    logic [31:0]       lo, lo_nxt;
    logic [63:0]       result;
    md_op_e            op_in;
    logic              launch_mul;
    logic              launch_div;

    function automatic logic [63:0] mul_s(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] xs;
        logic signed [63:0] ys;
        xs = {{32{x[31]}}, x};
        ys = {{32{y[31]}}, y};
        return xs * ys;
    endfunction

    function automatic logic [63:0] mul_u(input logic [31:0] x, input logic [31:0] y);
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Returns {remainder, quotient}; zero divisor and the one overflowing
    // signed quotient are pinned to their architectural values.
    function automatic logic [63:0] div_s(input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] xs;
        logic signed [31:0] ys;
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (y == 32'd0) begin
            return {x, 32'hFFFF_FFFF};
        end
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            return {32'd0, 32'h8000_0000};
        end
        xs = x;
        ys = y;
        q  = xs / ys;
        r  = xs % ys;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_u(input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) begin
            return {x, 32'hFFFF_FFFF};
        end
        return {x % y, x / y};
    endfunction

    // Result of the in-flight op, formed from the latched operands
    always_comb begin
        result = {hi, lo};
        case (op_p0)
            MD_MULT:  result = mul_s(a_p0, b_p0);
            MD_MULTU: result = mul_u(a_p0, b_p0);
            MD_DIV:   result = div_s(a_p0, b_p0);
            MD_DIVU:  result = div_u(a_p0, b_p0);
`ifdef MDU_MADD_EN
            MD_MADD:  result = {hi, lo} + mul_s(a_p0, b_p0);
`endif
            default:  result = {hi, lo};
        endcase
    end

    // Controller next state: acceptance, count-down and commit
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        op_nxt     = op_p0;
        a_nxt      = a_p0;
        b_nxt      = b_p0;
        hi_nxt     = hi;
        lo_nxt     = lo;
        op_in      = md_op_e'(md.MDOp);
        launch_mul = (op_in == MD_MULT) || (op_in == MD_MULTU);
`ifdef MDU_MADD_EN
        launch_mul = launch_mul || (op_in == MD_MADD);
`endif
        launch_div = (op_in == MD_DIV) || (op_in == MD_DIVU);

        case (state)
            ST_IDLE: begin
                if (md.Start) begin
                    if (launch_mul || launch_div) begin
                        op_nxt    = op_in;
                        a_nxt     = md.A;
                        b_nxt     = md.B;
                        cnt_nxt   = launch_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_nxt = ST_RUN;
                    end else if (op_in == MD_MTHI) begin
                        hi_nxt = md.A;
                    end else if (op_in == MD_MTLO) begin
                        lo_nxt = md.A;
                    end
                end
            end
            ST_RUN: begin
                // Start is ignored here; the hazard unit stalls instead
                if (cnt <= CNT_W'(1)) begin
                    hi_nxt    = result[63:32];
                    lo_nxt    = result[31:0];
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and HI/LO registers; latched operands need no reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
        end
        op_p0 <= op_nxt;
        a_p0  <= a_nxt;
        b_p0  <= b_nxt;
    end

    assign md.Busy = (state == ST_RUN);
    assign md.HI   = hi;
    assign md.LO   = lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases followed by
// randomized traffic, all compared cycle by cycle against a transaction
// model that tracks the busy window by completion time.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk;
    logic reset;
    mdu_if bus();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int          edge_n = 0;
    int          m_done = 0;
    bit          m_busy = 1'b0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [63:0] m_pend = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] acc);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_MULT:  return sa * sb;
            MD_MULTU: return ua * ub;
            MD_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default:  return acc + 64'(sa * sb);
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic s, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        edge_n++;
        if (r) begin
            m_busy = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end else if (m_busy) begin
            if (edge_n == m_done) begin
                {m_hi, m_lo} = m_pend;
                m_busy = 1'b0;
            end
        end else if (s) begin
            case (op)
                MD_MULT, MD_MULTU: begin
                    m_busy = 1'b1; m_done = edge_n + 5; m_pend = ref_result(op, a, b, {m_hi, m_lo});
                end
                MD_DIV, MD_DIVU: begin
                    m_busy = 1'b1; m_done = edge_n + 10; m_pend = ref_result(op, a, b, {m_hi, m_lo});
                end
                MD_MTHI: m_hi = a;
                MD_MTLO: m_lo = a;
                MD_MADD: begin
`ifdef MDU_MADD_EN
                    m_busy = 1'b1; m_done = edge_n + 5; m_pend = ref_result(op, a, b, {m_hi, m_lo});
`endif
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        reset     = r;
        bus.Start = s;
        bus.MDOp  = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        model_edge(r, s, op, a, b);
        #1;
        check_val("busy", {31'd0, bus.Busy}, {31'd0, m_busy});
        check_val("hi", bus.HI, m_hi);
        check_val("lo", bus.LO, m_lo);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    // counts cycles still observed busy, bounded
    task automatic run_until_idle(output int n);
        n = 0;
        while (bus.Busy && n < 50) begin
            n++;
            idle();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [2:0]  op;
        logic [31:0] a, b;
        reset     = 1'b1;
        bus.Start = 1'b0;
        bus.MDOp  = '0;
        bus.A     = '0;
        bus.B     = '0;

        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        step(1'b1, 1'b1, MD_MTHI, 32'h1234, 32'd0);
        check_val("reset_hi", bus.HI, 32'd0);
        check_val("reset_busy", {31'd0, bus.Busy}, 32'd0);

        // MULT signed
        step(1'b0, 1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3);
        run_until_idle(n);
        check_val("mult_busy_cycles", n, 32'd5);
        check_val("mult_hi", bus.HI, 32'hFFFF_FFFF);
        check_val("mult_lo", bus.LO, 32'hFFFF_FFFA);

        // MULTU issued back-to-back in the first non-busy cycle
        step(1'b0, 1'b1, MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        run_until_idle(n);
        check_val("multu_busy_cycles", n, 32'd5);
        check_val("multu_hi", bus.HI, 32'd2);
        check_val("multu_lo", bus.LO, 32'hFFFF_FFFA);

        // DIV with an ignored Start during busy
        step(1'b0, 1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2);
        step(1'b0, 1'b1, MD_MTHI, 32'h5555_5555, 32'd0);
        run_until_idle(n);
        check_val("div_busy_remaining", n, 32'd9);
        check_val("div_lo", bus.LO, 32'hFFFF_FFFD);
        check_val("div_hi", bus.HI, 32'hFFFF_FFFF);

        // DIVU by zero
        step(1'b0, 1'b1, MD_DIVU, 32'd5, 32'd0);
        run_until_idle(n);
        check_val("divz_busy_cycles", n, 32'd10);
        check_val("divz_hi", bus.HI, 32'd5);
        check_val("divz_lo", bus.LO, 32'hFFFF_FFFF);

        // signed overflow divide
        step(1'b0, 1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_until_idle(n);
        check_val("divov_lo", bus.LO, 32'h8000_0000);
        check_val("divov_hi", bus.HI, 32'd0);

        // reset in cycle 3 of a DIV, with a competing Start
        step(1'b0, 1'b1, MD_DIV, 32'd100, 32'd7);
        idle();
        step(1'b1, 1'b1, MD_MTLO, 32'd77, 32'd0);
        check_val("abort_busy", {31'd0, bus.Busy}, 32'd0);
        check_val("abort_hi", bus.HI, 32'd0);
        check_val("abort_lo", bus.LO, 32'd0);
        step(1'b0, 1'b1, MD_MTLO, 32'd9, 32'd0);
        check_val("mtlo_lo", bus.LO, 32'd9);
        check_val("mtlo_busy", {31'd0, bus.Busy}, 32'd0);

        // reserved op
        step(1'b0, 1'b1, MD_RSVD, 32'hDEAD, 32'hBEEF);
        check_val("rsvd_busy", {31'd0, bus.Busy}, 32'd0);
        check_val("rsvd_lo", bus.LO, 32'd9);

        // MADD
        step(1'b0, 1'b1, MD_MTHI, 32'd0, 32'd0);
        step(1'b0, 1'b1, MD_MTLO, 32'hFFFF_FFFF, 32'd0);
        step(1'b0, 1'b1, MD_MADD, 32'd1, 32'd1);
        run_until_idle(n);
`ifdef MDU_MADD_EN
        check_val("madd_busy_cycles", n, 32'd5);
        check_val("madd_hi", bus.HI, 32'd1);
        check_val("madd_lo", bus.LO, 32'd0);
`else
        check_val("madd_busy_cycles", n, 32'd0);
        check_val("madd_hi", bus.HI, 32'd0);
        check_val("madd_lo", bus.LO, 32'hFFFF_FFFF);
`endif

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), op, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
